// File: rtl/cache_stats_counter.sv
// Cache event statistics: nine saturating live counters with frame-stable snapshot
// registers, so the statistics display never shows a half-updated set of totals.
module cache_stats_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          ev_valid,
    input  logic          ev_write,
    input  logic          ev_hit,
    input  logic          ev_evict,
    input  logic          inst_retire,
    input  logic          snap,
    output logic [CW-1:0] accessesTotal,
    output logic [CW-1:0] evictionTotal,
    output logic [CW-1:0] writeHitTotal,
    output logic [CW-1:0] readHitTotal,
    output logic [CW-1:0] writeMissTotal,
    output logic [CW-1:0] readMissTotal,
    output logic [CW-1:0] instTotal,
    output logic [CW-1:0] hitTotal,
    output logic [CW-1:0] missTotal,
    output logic          snap_done,
    output logic          sat,
    output logic          err
);

    localparam int NCNT = 9;

    // Counter slots: 0 access, 1 evict, 2 write hit, 3 read hit, 4 write miss,
    // 5 read miss, 6 inst, 7 hit, 8 miss.
    logic [NCNT-1:0] inc;
    logic [NCNT-1:0] at_max;
    logic [CW-1:0]   live_reg [NCNT];
    logic [CW-1:0]   snap_reg [NCNT];
    logic            snap_done_reg;
    logic            sat_reg;
    logic            err_reg;

    always_comb begin
        inc    = '0;
        inc[0] = ev_valid;
        inc[1] = ev_valid & ~ev_hit & ev_evict;
        inc[2] = ev_valid & ev_write & ev_hit;
        inc[3] = ev_valid & ~ev_write & ev_hit;
        inc[4] = ev_valid & ev_write & ~ev_hit;
        inc[5] = ev_valid & ~ev_write & ~ev_hit;
        inc[6] = inst_retire;
        inc[7] = ev_valid & ev_hit;
        inc[8] = ev_valid & ~ev_hit;
    end

    generate
        for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
            assign at_max[gi] = &live_reg[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    live_reg[gi] <= '0;
                end else if (clear) begin
                    live_reg[gi] <= '0;
                end else if (inc[gi] && !at_max[gi]) begin
                    live_reg[gi] <= live_reg[gi] + 1'b1;
                end
            end

            // Captures the pre-edge live value, so a same-cycle event or clear is excluded.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    snap_reg[gi] <= '0;
                end else if (snap) begin
                    snap_reg[gi] <= live_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_done_reg <= 1'b0;
            sat_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            snap_done_reg <= snap;
            sat_reg       <= clear ? 1'b0 : (sat_reg | (|(inc & at_max)));
            err_reg       <= err_reg | (ev_valid & ev_hit & ev_evict);
        end
    end

    assign accessesTotal  = snap_reg[0];
    assign evictionTotal  = snap_reg[1];
    assign writeHitTotal  = snap_reg[2];
    assign readHitTotal   = snap_reg[3];
    assign writeMissTotal = snap_reg[4];
    assign readMissTotal  = snap_reg[5];
    assign instTotal      = snap_reg[6];
    assign hitTotal       = snap_reg[7];
    assign missTotal      = snap_reg[8];
    assign snap_done      = snap_done_reg;
    assign sat            = sat_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_cache_stats_counter.sv
// Bench for cache_stats_counter (CW=4 so saturation is reachable): table vectors,
// hand sequences for corner cases, and a snapshot scoreboard fed by a live-count model.
module tb_cache_stats_counter;

    localparam int CW = 4;
    typedef logic [0:8][CW-1:0] tot_t;

    typedef struct {
        logic v, w, h, e, i;
        int   reps;
        tot_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset, clear, ev_valid, ev_write, ev_hit, ev_evict, inst_retire, snap;
    logic [CW-1:0] accessesTotal, evictionTotal, writeHitTotal, readHitTotal;
    logic [CW-1:0] writeMissTotal, readMissTotal, instTotal, hitTotal, missTotal;
    logic snap_done, sat, err;

    cache_stats_counter #(.CW(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .ev_valid(ev_valid),
        .ev_write(ev_write), .ev_hit(ev_hit), .ev_evict(ev_evict),
        .inst_retire(inst_retire), .snap(snap),
        .accessesTotal(accessesTotal), .evictionTotal(evictionTotal),
        .writeHitTotal(writeHitTotal), .readHitTotal(readHitTotal),
        .writeMissTotal(writeMissTotal), .readMissTotal(readMissTotal),
        .instTotal(instTotal), .hitTotal(hitTotal), .missTotal(missTotal),
        .snap_done(snap_done), .sat(sat), .err(err)
    );

    always #5 clk = ~clk;

    tot_t totals;
    assign totals = {accessesTotal, evictionTotal, writeHitTotal, readHitTotal,
                     writeMissTotal, readMissTotal, instTotal, hitTotal, missTotal};

    int   n_pass  = 0;
    int   n_total = 0;
    tot_t live_m, snap_m;
    logic sat_m, err_m;
    tot_t sb_q[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        live_m = '0; snap_m = '0; sat_m = 1'b0; err_m = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, advance past the edge, update the model, compare.
    task automatic cycle(input logic v, w, h, e, i, s, c);
        logic [0:8] incm;
        tot_t exp_snap;
        ev_valid = v; ev_write = w; ev_hit = h; ev_evict = e;
        inst_retire = i; snap = s; clear = c;
        if (s) sb_q.push_back(live_m);
        @(posedge clk);
        #1;
        incm = {v, v & !h & e, v & w & h, v & !w & h, v & w & !h, v & !w & !h,
                i, v & h, v & !h};
        err_m = err_m | (v & h & e);
        if (c) begin
            live_m = '0;
            sat_m  = 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (incm[k]) begin
                    if (live_m[k] == {CW{1'b1}}) sat_m = 1'b1;
                    else live_m[k] = live_m[k] + 1'b1;
                end
            end
        end
        if (s) begin
            exp_snap = sb_q.pop_front();
            snap_m = exp_snap;
        end
        $display("cycle v=%b w=%b h=%b e=%b i=%b snap=%b clr=%b totals=%h done=%b sat=%b err=%b",
                 v, w, h, e, i, s, c, totals, snap_done, sat, err);
        chk("snap_done", snap_done, s);
        chk("totals", totals, snap_m);
        chk("sat", sat, sat_m);
        chk("err", err, err_m);
    endtask

    task automatic idle(input logic s, c);
        cycle(0, 0, 0, 0, 0, s, c);
    endtask

    initial begin
        vecs[0] = '{v:1, w:0, h:1, e:0, i:0, reps:3, exp:'{3, 0, 0, 3, 0, 0, 0, 3, 0}};
        vecs[1] = '{v:1, w:1, h:0, e:1, i:1, reps:2, exp:'{2, 2, 0, 0, 2, 0, 2, 0, 2}};
        vecs[2] = '{v:0, w:1, h:1, e:1, i:1, reps:4, exp:'{0, 0, 0, 0, 0, 0, 4, 0, 0}};
        vecs[3] = '{v:1, w:1, h:1, e:0, i:0, reps:5, exp:'{5, 0, 5, 0, 0, 0, 0, 5, 0}};
        vecs[4] = '{v:1, w:0, h:0, e:0, i:1, reps:6, exp:'{6, 0, 0, 0, 0, 6, 6, 0, 6}};
        vecs[5] = '{v:1, w:0, h:0, e:1, i:0, reps:1, exp:'{1, 1, 0, 0, 0, 1, 0, 0, 1}};

        reset = 1'b1; clear = 0; ev_valid = 0; ev_write = 0; ev_hit = 0;
        ev_evict = 0; inst_retire = 0; snap = 0;
        model_reset();
        #12;
        chk("reset_totals", totals, '0);
        chk("reset_done", snap_done, 1'b0);
        chk("reset_sat", sat, 1'b0);
        chk("reset_err", err, 1'b0);
        reset = 1'b0;

        // Basic mix: 3 read hits, 2 write misses (one evicting), 4 retires.
        for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1, 0, 0);
        idle(1, 0);
        chk("mix_snap", totals, tot_t'({4'd5, 4'd1, 4'd0, 4'd3, 4'd2, 4'd0, 4'd4, 4'd3, 4'd2}));
        idle(0, 0);

        // Table vectors, each from a cleared state.
        for (int n = 0; n < 6; n++) begin
            idle(0, 1);
            for (int r = 0; r < vecs[n].reps; r++)
                cycle(vecs[n].v, vecs[n].w, vecs[n].h, vecs[n].e, vecs[n].i, 0, 0);
            idle(1, 0);
            chk($sformatf("vec%0d", n), totals, vecs[n].exp);
        end

        // Event on the snap edge is excluded, then included by the next snap.
        idle(0, 1);
        cycle(1, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 1, 0);
        chk("snap_excl", accessesTotal, 4'd1);
        idle(1, 0);
        chk("snap_incl", accessesTotal, 4'd2);

        // Held snap: reloads and snap_done stays high every cycle.
        idle(1, 0);
        idle(1, 0);
        idle(0, 0);

        // Saturation at all-ones.
        idle(0, 1);
        for (int k = 0; k < 15; k++) cycle(1, 0, 0, 0, 0, 0, 0);
        chk("sat_before", sat, 1'b0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("sat_after", sat, 1'b1);
        idle(1, 0);
        chk("rm_sat", readMissTotal, 4'd15);
        idle(0, 1);
        chk("sat_cleared", sat, 1'b0);
        chk("rm_kept", readMissTotal, 4'd15);
        idle(1, 0);
        chk("rm_zero", readMissTotal, 4'd0);

        // Hit with evict: eviction dropped, hit counted, err sticky through clear.
        cycle(1, 0, 1, 1, 0, 0, 0);
        chk("err_set", err, 1'b1);
        idle(1, 0);
        chk("evict_drop", evictionTotal, 4'd0);
        chk("hit_count", hitTotal, 4'd1);
        idle(0, 1);
        chk("err_sticky", err, 1'b1);

        // clear + event + snap together: snapshot keeps prior, next snap is zero.
        cycle(1, 1, 1, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 1, 1);
        chk("clr_snap_wh", writeHitTotal, 4'd2);
        idle(1, 0);
        chk("clr_snap_zero", totals, '0);

        // Asynchronous reset between edges, mid snap_done pulse.
        cycle(1, 0, 1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 1, 1, 0);
        #2 reset = 1'b1;
        #1;
        $display("async reset: totals=%h done=%b sat=%b err=%b", totals, snap_done, sat, err);
        chk("areset_totals", totals, '0);
        chk("areset_done", snap_done, 1'b0);
        chk("areset_err", err, 1'b0);
        model_reset();
        #1 reset = 1'b0;
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        idle(1, 0);
        chk("resume_access", accessesTotal, 4'd2);
        chk("resume_wm", writeMissTotal, 4'd2);
        idle(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
